control_unit: RTL
=================

# control_unit

Instruction sequencer that sits directly upstream of `datapath`. It latches `current_instruction`, decodes it and drives every datapath control input (ALU operand and op selects, load/store enables, PC increment, VGA selects). It also runs a fetch/decode/execute state machine with a handshake to the VGA plotter. One instruction completes every 3 cycles, or 4 for loads, plus any plot wait.

## Interface
- No parameters; instruction width fixed at 16 bits.
- `clock` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `current_instruction` in 16: instruction at PC from `datapath`.
- `zeroflag`, `signflag` in 16 each: per-register flags from `datapath`.
- `run` in 1: level; 0 holds the sequencer in FETCH.
- `plot_ready` in 1: VGA plotter accepts a pixel.
- `program_counter_increment`, `alu_a_source`, `alu_b_source`, `alu_store_to_mem`, `alu_store_to_stk` out 1 each: datapath controls.
- `alu_op`, `alu_a_select`, `alu_b_select`, `alu_out_select`, `vga_color_select`, `vga_coord_select` out 4 each.
- `alu_a_altern`, `alu_b_altern` out 16 each.
- `alu_load_src` out 2: 00 none, 01 ALU result, 10 memory, 11 stack.
- `plot` out 1: pixel valid to the VGA plotter.
- `halted` out 1, sticky.
- `illegal` out 1, sticky.
- `state` out 3: debug state encoding.

## Operation
- Instruction format: `[15:12]` opcode, `[11:8]` rd, `[7:4]` ra, `[3:0]` rb; imm8 = `[7:0]` sign-extended to 16 bits.
- 0x0 HALT: go to HALT.
- 0x1–0x7 ALU: `alu_op`=opcode, a=ra, b=rb, `alu_out_select`=rd, `alu_load_src`=01.
- 0x8 LDI: `alu_a_source`=1, `alu_a_altern`=imm8, `alu_op`=0 (pass A), dest rd, load_src 01.
- 0x9 LOAD: rd ← mem[ra]. Address is ra passed through the ALU; load_src 10, asserted only in MEM.
- 0xA STORE: mem[ra] ← rd. `alu_store_to_mem`=1, `alu_out_select`=rd.
- 0xB PUSH: same as STORE but with `alu_store_to_stk`=1.
- 0xC BRZ: if `zeroflag[rd]`, r0 ← r0 + imm8. Drive a=0, `alu_b_source`=1, `alu_b_altern`=imm8, `alu_op`=1 (ADD), dest 0, load_src 01, no PC increment. If not taken, increment the PC only.
- 0xD BRN: same as BRZ, using `signflag[rd]`.
- 0xE PLOT: `vga_color_select`=rd, `vga_coord_select`=ra; assert `plot` until `plot_ready`.
- 0xF: sets `illegal` and goes to HALT.
- States: FETCH(0) → DECODE(1) → EXEC(2) → FETCH; LOAD goes EXEC → MEM(3) → FETCH; PLOT goes EXEC → PWAIT(4) → FETCH; HALT(5) is terminal until reset.
- FETCH: leave only when `run`=1.
- DECODE: `ir` ← `current_instruction`.
- EXEC: decoded controls asserted for exactly one cycle.
- All control outputs are 0 in FETCH, DECODE and HALT; `alu_*_select` hold 0.
- `program_counter_increment`=1 for exactly one cycle per non-taken instruction: in EXEC, or in MEM for LOAD, or on the `plot_ready` cycle for PLOT. HALT and illegal opcodes do not increment.

## Timing
- Reset: state FETCH, `ir`=0, and every output is 0, including `halted`, `illegal` and `plot`.
- Latency: 3 cycles per instruction; LOAD takes 4; PLOT takes 3 + N, where N is the number of wait cycles.
- Handshake: `plot` rises in EXEC and stays high with constant selects until the cycle `plot_ready`=1. Transfer happens in that cycle; `plot` is 0 the next cycle. If `plot_ready`=1 already in EXEC, the transfer completes in EXEC with no PWAIT.
- `run` dropping mid-instruction does not abort; the sequencer stops at the next FETCH.
- `resetn`=0 in any state, including PWAIT with `plot` high, returns to reset values on the next edge.
- imm8 sign extension: 0x80 → 0xFF80. r0 add wraps modulo 2^16 (done in datapath).

## Configuration
- `CONTROL_STEP_EN` defined: adds input `step` (1 bit). FETCH then advances only when `run`=1 and `step`=1, so one instruction executes per step pulse; a held `step` still yields one instruction per FETCH visit.
- Not defined: no `step` port; FETCH depends on `run` only.

## Test plan
- Reset: `resetn`=0 for 2 cycles → every output 0, `state`=0. Release with `run`=1 → DECODE on the next cycle.
- 0x1312 → EXEC shows `alu_op`=1, a=1, b=2, out=3, load_src=01, PC inc=1 for one cycle; the next instruction's DECODE comes 3 cycles after the previous DECODE.
- BRZ 0xC2FE with `zeroflag[2]`=1 → `alu_b_altern`=0xFFFE, dest 0, PC inc=0. With `zeroflag[2]`=0 → only PC inc=1.
- LOAD 0x9540 → MEM cycle has load_src=10, out=5, PC inc=1. PLOT 0xE120 with `plot_ready` low for 3 cycles → `plot` high for 4 cycles, PC inc only on the accepting cycle.
- Opcode 0xF000 → `illegal`=1, `halted`=1, no PC inc. Reset asserted during PWAIT → `plot`=0 the next cycle.
- With `CONTROL_STEP_EN`: `run`=1, `step` held low for 10 cycles → stays in FETCH. One-cycle `step` pulse → exactly one instruction executes.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Fetch/decode/execute sequencer driving datapath and VGA plotter
//               controls. Optional single-step gating via CONTROL_STEP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit (
    input  logic        clock,
    input  logic        resetn,
`ifdef CONTROL_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] current_instruction,
    input  logic [15:0] zeroflag,
    input  logic [15:0] signflag,
    input  logic        run,
    input  logic        plot_ready,
    output logic        program_counter_increment,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic [3:0]  alu_out_select,
    output logic [3:0]  vga_color_select,
    output logic [3:0]  vga_coord_select,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [1:0]  alu_load_src,
    output logic        plot,
    output logic        halted,
    output logic        illegal,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_PWAIT  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] LOAD_NONE = 2'b00;
    localparam logic [1:0] LOAD_ALU  = 2'b01;
    localparam logic [1:0] LOAD_MEM  = 2'b10;

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] ir;
    logic        go;
    logic        taken;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;

    assign opcode = ir[15:12];
    assign rd     = ir[11:8];
    assign ra     = ir[7:4];
    assign rb     = ir[3:0];
    assign imm    = {{8{ir[7]}}, ir[7:0]};
    assign taken  = (opcode == 4'hC) ? zeroflag[rd] : signflag[rd];
    assign state  = cur_state;

`ifdef CONTROL_STEP_EN
    assign go = run & step;
`else
    assign go = run;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cur_state <= S_FETCH;
            ir        <= 16'h0000;
            halted    <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE)
                ir <= current_instruction;
            if (nxt_state == S_HALT)
                halted <= 1'b1;
            if (cur_state == S_EXEC && opcode == 4'hF)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        nxt_state                 = cur_state;
        program_counter_increment = 1'b0;
        alu_a_source              = 1'b0;
        alu_b_source              = 1'b0;
        alu_store_to_mem          = 1'b0;
        alu_store_to_stk          = 1'b0;
        alu_op                    = 4'h0;
        alu_a_select              = 4'h0;
        alu_b_select              = 4'h0;
        alu_out_select            = 4'h0;
        vga_color_select          = 4'h0;
        vga_coord_select          = 4'h0;
        alu_a_altern              = 16'h0000;
        alu_b_altern              = 16'h0000;
        alu_load_src              = LOAD_NONE;
        plot                      = 1'b0;

        case (cur_state)
            S_FETCH: begin
                if (go)
                    nxt_state = S_DECODE;
            end
            S_DECODE: nxt_state = S_EXEC;
            S_EXEC: begin
                nxt_state = S_FETCH;
                case (opcode)
                    4'h0: nxt_state = S_HALT;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        alu_op                    = opcode;
                        alu_a_select              = ra;
                        alu_b_select              = rb;
                        alu_out_select            = rd;
                        alu_load_src              = LOAD_ALU;
                        program_counter_increment = 1'b1;
                    end
                    4'h8: begin
                        alu_a_source              = 1'b1;
                        alu_a_altern              = imm;
                        alu_out_select            = rd;
                        alu_load_src              = LOAD_ALU;
                        program_counter_increment = 1'b1;
                    end
                    // Address is presented here; the register write lands in MEM.
                    4'h9: begin
                        alu_a_select   = ra;
                        alu_out_select = rd;
                        nxt_state      = S_MEM;
                    end
                    4'hA, 4'hB: begin
                        alu_a_select              = ra;
                        alu_out_select            = rd;
                        alu_store_to_mem          = (opcode == 4'hA);
                        alu_store_to_stk          = (opcode == 4'hB);
                        program_counter_increment = 1'b1;
                    end
                    4'hC, 4'hD: begin
                        if (taken) begin
                            alu_b_source   = 1'b1;
                            alu_b_altern   = imm;
                            alu_op         = 4'h1;
                            alu_load_src   = LOAD_ALU;
                        end else begin
                            program_counter_increment = 1'b1;
                        end
                    end
                    4'hE: begin
                        plot             = 1'b1;
                        vga_color_select = rd;
                        vga_coord_select = ra;
                        if (plot_ready)
                            program_counter_increment = 1'b1;
                        else
                            nxt_state = S_PWAIT;
                    end
                    default: nxt_state = S_HALT;
                endcase
            end
            S_MEM: begin
                alu_a_select              = ra;
                alu_out_select            = rd;
                alu_load_src              = LOAD_MEM;
                program_counter_increment = 1'b1;
                nxt_state                 = S_FETCH;
            end
            S_PWAIT: begin
                plot             = 1'b1;
                vga_color_select = rd;
                vga_coord_select = ra;
                if (plot_ready) begin
                    program_counter_increment = 1'b1;
                    nxt_state                 = S_FETCH;
                end
            end
            S_HALT:  nxt_state = S_HALT;
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire
